// File: rtl/ptp_bridge_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ptp_bridge_dbg_pkg
// Purpose  : Shared register-map constants and helpers for the debug counter bank.
// Revision : 1.0 - initial release
// ============================================================================
package ptp_bridge_dbg_pkg;

    localparam int          c_CLR_ALL_BIT = 0;
    localparam int          c_FREEZE_BIT  = 1;
    localparam logic [31:0] c_UNMAPPED_RD = 32'h0000_0000;

    function automatic int wpc(input int cntr_width);
        return cntr_width / 32;
    endfunction

    // The control register sits directly after the last counter word.
    function automatic int ctrl_offset(input int num_cntr, input int cntr_width);
        return num_cntr * wpc(cntr_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptp_bridge_dbg_cntr_cell.sv
`default_nettype none
// ============================================================================
// Module   : ptp_bridge_dbg_cntr_cell
// Purpose  : One event counter with freeze, wrap/saturate, clear and clear-on-read.
// Revision : 1.0 - initial release
// ============================================================================
module ptp_bridge_dbg_cntr_cell
    import ptp_bridge_dbg_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_freeze,
    input  logic             i_clr,
    input  logic             i_rd_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_inc;
    logic             w_at_max;

    assign w_inc    = i_inc & ~i_freeze;
    assign w_at_max = &r_cnt;

    // A read-clear that coincides with an increment leaves the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_rd_clr) begin
            r_cnt <= {{(WIDTH-1){1'b0}}, w_inc};
        end else if (w_inc) begin
            if (!w_at_max) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end else if (SATURATE == 0) begin
                r_cnt <= '0;
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ptp_bridge_rx_dbg_cntr_bank.sv
`default_nettype none
// ============================================================================
// Module   : ptp_bridge_rx_dbg_cntr_bank
// Purpose  : AVMM-readable bank of debug event counters with freeze/clear control.
//            Optional: PTP_BRIDGE_DBG_CNTR_CLR_ON_READ_EN makes low-word reads clear.
// Revision : 1.0 - initial release
// ============================================================================
module ptp_bridge_rx_dbg_cntr_bank
    import ptp_bridge_dbg_pkg::*;
#(
    parameter int                    NUM_CNTR   = 16,
    parameter int                    CNTR_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0,
    parameter int                    SATURATE   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CNTR-1:0]            cntr_inc,
    input  logic [ADDR_WIDTH-1:0]          avmm_address,
    input  logic                           avmm_read,
    input  logic                           avmm_write,
    input  logic [DATA_WIDTH-1:0]          avmm_writedata,
    input  logic [3:0]                     avmm_byteenable,
    output logic [DATA_WIDTH-1:0]          avmm_readdata,
    output logic                           avmm_readdatavalid,
    output logic [NUM_CNTR*CNTR_WIDTH-1:0] cntr_snapshot
);

    localparam int c_WPC      = wpc(CNTR_WIDTH);
    localparam int c_CTRL_OFF = ctrl_offset(NUM_CNTR, CNTR_WIDTH);

    typedef logic [ADDR_WIDTH:0] off_t;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd;
    logic                  r_wr;
    logic                  r_wd_clr;
    logic                  r_wd_freeze;
    logic                  r_be0;
    logic                  r_freeze;
    logic                  r_rdv;
    logic [DATA_WIDTH-1:0] r_rdata;

    off_t                  w_off;
    logic                  w_ctrl_sel;
    logic                  w_rd_only;
    logic                  w_ctrl_wr;
    logic                  w_clr_all;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [NUM_CNTR-1:0]   w_lo_sel;
    logic [NUM_CNTR-1:0]   w_hi_sel;
    logic [NUM_CNTR-1:0]   w_lo_sample;
    logic [DATA_WIDTH-1:0] w_word_lo [NUM_CNTR];
    logic [DATA_WIDTH-1:0] w_word_hi [NUM_CNTR];
    logic                  w_unused;

    assign w_unused = ^{avmm_writedata, avmm_byteenable[3:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_wd_clr    <= 1'b0;
            r_wd_freeze <= 1'b0;
            r_be0       <= 1'b0;
        end else begin
            r_addr      <= avmm_address;
            r_rd        <= avmm_read;
            r_wr        <= avmm_write;
            r_wd_clr    <= avmm_writedata[c_CLR_ALL_BIT];
            r_wd_freeze <= avmm_writedata[c_FREEZE_BIT];
            r_be0       <= avmm_byteenable[0];
        end
    end

    // Zero-extended subtraction: addresses below BASE_ADDR borrow into the
    // top bit and so can never match an in-range offset.
    assign w_off      = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_ctrl_sel = (w_off == off_t'(c_CTRL_OFF));
    assign w_rd_only  = r_rd & ~r_wr;
    assign w_ctrl_wr  = r_wr & w_ctrl_sel & r_be0;
    assign w_clr_all  = w_ctrl_wr & r_wd_clr;

    for (genvar i = 0; i < NUM_CNTR; i++) begin : g_cntr
        logic [CNTR_WIDTH-1:0] w_cnt;
        logic                  w_rd_clr;

        assign w_lo_sel[i]    = (w_off == off_t'(i * c_WPC));
        assign w_lo_sample[i] = w_rd_only & w_lo_sel[i];

`ifdef PTP_BRIDGE_DBG_CNTR_CLR_ON_READ_EN
        assign w_rd_clr = w_lo_sample[i];
`else
        assign w_rd_clr = 1'b0;
`endif

        ptp_bridge_dbg_cntr_cell #(
            .WIDTH    (CNTR_WIDTH),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .i_inc    (cntr_inc[i]),
            .i_freeze (r_freeze),
            .i_clr    (w_clr_all),
            .i_rd_clr (w_rd_clr),
            .o_cnt    (w_cnt)
        );

        assign cntr_snapshot[i*CNTR_WIDTH +: CNTR_WIDTH] = w_cnt;
        assign w_word_lo[i] = w_cnt[DATA_WIDTH-1:0];

        if (c_WPC == 2) begin : g_hi
            // Shadow keeps the high half coherent with the low half read earlier.
            logic [DATA_WIDTH-1:0] r_shadow;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow <= '0;
                end else if (w_clr_all) begin
                    r_shadow <= '0;
                end else if (w_lo_sample[i]) begin
                    r_shadow <= w_cnt[CNTR_WIDTH-1 -: DATA_WIDTH];
                end
            end

            assign w_hi_sel[i]  = (w_off == off_t'(i * c_WPC + 1));
            assign w_word_hi[i] = r_shadow;
        end else begin : g_no_hi
            assign w_hi_sel[i]  = 1'b0;
            assign w_word_hi[i] = '0;
        end
    end

    always_comb begin
        w_rdata = c_UNMAPPED_RD;
        for (int i = 0; i < NUM_CNTR; i++) begin
            if (w_lo_sel[i]) w_rdata = w_word_lo[i];
            if (w_hi_sel[i]) w_rdata = w_word_hi[i];
        end
        if (w_ctrl_sel) begin
            w_rdata               = '0;
            w_rdata[c_FREEZE_BIT] = r_freeze;
        end
    end

    // A read colliding with a write still completes, but returns zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freeze <= 1'b0;
            r_rdv    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_freeze <= r_wd_freeze;
            end
            r_rdv   <= r_rd;
            r_rdata <= w_rd_only ? w_rdata : '0;
        end
    end

    assign avmm_readdata      = r_rdata;
    assign avmm_readdatavalid = r_rdv;

endmodule
`default_nettype wire

// File: tb/tb_ptp_bridge_rx_dbg_cntr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptp_bridge_rx_dbg_cntr_bank
// Purpose  : Directed self-checking bench for the debug counter bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptp_bridge_rx_dbg_cntr_bank;

`ifdef PTP_BRIDGE_DBG_CNTR_CLR_ON_READ_EN
    localparam bit COR = 1'b1;
`else
    localparam bit COR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] inc_m;
    logic [3:0]  inc_w;
    logic [1:0]  inc_s;
    logic [7:0]  avmm_address;
    logic        avmm_read;
    logic        avmm_write;
    logic [31:0] avmm_writedata;
    logic [3:0]  avmm_byteenable;

    logic [31:0]      rdata_m, rdata_w, rdata_s;
    logic             rdv_m, rdv_w, rdv_s;
    logic [16*32-1:0] snap_m;
    logic [4*64-1:0]  snap_w;
    logic [2*32-1:0]  snap_s;

    int          tests  = 0;
    int          failed = 0;
    logic [31:0] rd_m, rd_w, rd_s;
    logic        v_e1, v_e2, v_e3;

    ptp_bridge_rx_dbg_cntr_bank u_dut (
        .clk(clk), .rst(rst), .cntr_inc(inc_m),
        .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_readdata(rdata_m), .avmm_readdatavalid(rdv_m), .cntr_snapshot(snap_m)
    );

    ptp_bridge_rx_dbg_cntr_bank #(.NUM_CNTR(4), .CNTR_WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .cntr_inc(inc_w),
        .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_readdata(rdata_w), .avmm_readdatavalid(rdv_w), .cntr_snapshot(snap_w)
    );

    ptp_bridge_rx_dbg_cntr_bank #(.NUM_CNTR(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .cntr_inc(inc_s),
        .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_readdata(rdata_s), .avmm_readdatavalid(rdv_s), .cntr_snapshot(snap_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [15:0] m, input logic [3:0] w, input logic [1:0] s, input int n);
        inc_m = m;
        inc_w = w;
        inc_s = s;
        repeat (n) tick();
        inc_m = '0;
        inc_w = '0;
        inc_s = '0;
    endtask

    // One bus access; pbit >= 0 pulses inc_m[pbit] in the cycle the access is decoded.
    task automatic do_access(input logic [7:0] a, input logic rd, input logic wr,
                             input logic [31:0] d, input logic [3:0] be, input int pbit);
        avmm_address    = a;
        avmm_read       = rd;
        avmm_write      = wr;
        avmm_writedata  = d;
        avmm_byteenable = be;
        tick();
        avmm_read  = 1'b0;
        avmm_write = 1'b0;
        v_e1 = rdv_m;
        if (pbit >= 0) inc_m[pbit] = 1'b1;
        tick();
        inc_m = '0;
        v_e2 = rdv_m;
        rd_m = rdata_m;
        rd_w = rdata_w;
        rd_s = rdata_s;
        tick();
        v_e3 = rdv_m;
    endtask

    initial begin
        rst = 1'b1;
        inc_m = '0; inc_w = '0; inc_s = '0;
        avmm_address = '0; avmm_read = 1'b0; avmm_write = 1'b0;
        avmm_writedata = '0; avmm_byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata_m, 0);
        check("rst_rdv", rdv_m, 0);
        check("rst_snap", {63'b0, |{snap_m, snap_w, snap_s}}, 0);
        rst = 1'b0;
        tick();

        // Basic count and read latency
        pulse(16'h0008, 4'h0, 2'b00, 5);
        check("snap3_after5", snap_m[3*32 +: 32], 5);
        do_access(8'd3, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("lat_e1", v_e1, 0);
        check("lat_e2", v_e2, 1);
        check("lat_e3", v_e3, 0);
        check("rd3", rd_m, 5);

        do_access(8'd17, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("unmapped_rdv", v_e2, 1);
        check("unmapped_rd", rd_m, 0);

        do_access(8'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, -1);
        check("cntr_wr_ignored", snap_m[3*32 +: 32], COR ? 0 : 5);

        // Saturate vs wrap from all-ones
        force u_sat.g_cntr[0].u_cell.r_cnt = 32'hFFFF_FFFF;
        force u_dut.g_cntr[5].u_cell.r_cnt = 32'hFFFF_FFFF;
        #1;
        release u_sat.g_cntr[0].u_cell.r_cnt;
        release u_dut.g_cntr[5].u_cell.r_cnt;
        pulse(16'h0020, 4'h0, 2'b01, 3);
        check("sat_snap", snap_s[31:0], 32'hFFFF_FFFF);
        check("wrap_snap", snap_m[5*32 +: 32], 2);
        do_access(8'd0, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("sat_rd", rd_s, 32'hFFFF_FFFF);
        do_access(8'd5, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("wrap_rd", rd_m, 2);

        // 64-bit counter with shadowed high word
        force u_dut64.g_cntr[0].u_cell.r_cnt = 64'h1_FFFF_FFFE;
        #1;
        release u_dut64.g_cntr[0].u_cell.r_cnt;
        pulse(16'h0, 4'h1, 2'b00, 1);
        check("w64_snap", snap_w[63:0], 64'h1_FFFF_FFFF);
        do_access(8'd0, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("w64_rd_lo", rd_w, 32'hFFFF_FFFF);
        pulse(16'h0, 4'h1, 2'b00, 1);
        check("w64_snap2", snap_w[63:0], COR ? 64'h1 : 64'h2_0000_0000);
        do_access(8'd1, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("w64_rd_hi", rd_w, 1);

        // Simultaneous read and write
        pulse(16'h0080, 4'h0, 2'b00, 4);
        check("snap7", snap_m[7*32 +: 32], 4);
        do_access(8'd7, 1'b1, 1'b1, 32'h0, 4'hF, -1);
        check("rdwr_rdv", v_e2, 1);
        check("rdwr_rd", rd_m, 0);
        check("rdwr_snap7", snap_m[7*32 +: 32], 4);
        do_access(8'd7, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("rd7", rd_m, 4);

        // FREEZE, byte-enable gating, CLR_ALL
        do_access(8'd16, 1'b0, 1'b1, 32'h2, 4'h1, -1);
        do_access(8'd16, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("ctrl_freeze_rd", rd_m, 2);
        pulse(16'h0080, 4'h0, 2'b00, 10);
        check("frozen_snap7", snap_m[7*32 +: 32], COR ? 0 : 4);
        do_access(8'd16, 1'b0, 1'b1, 32'h0, 4'hE, -1);
        do_access(8'd16, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("ctrl_be0_ignored", rd_m, 2);
        do_access(8'd16, 1'b0, 1'b1, 32'h0, 4'h1, -1);
        do_access(8'd16, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("ctrl_unfreeze", rd_m, 0);
        pulse(16'h0080, 4'h0, 2'b00, 1);
        check("thawed_snap7", snap_m[7*32 +: 32], COR ? 1 : 5);
        do_access(8'd16, 1'b0, 1'b1, 32'h1, 4'h1, 7);
        check("clr_all_snap", {63'b0, |snap_m}, 0);
        do_access(8'd16, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("clr_self_clear", rd_m, 0);

        // Read coincident with an increment
        pulse(16'h0200, 4'h0, 2'b00, 7);
        do_access(8'd9, 1'b1, 1'b0, 32'h0, 4'h0, 9);
        check("rd9_coincident", rd_m, 7);
        do_access(8'd9, 1'b1, 1'b0, 32'h0, 4'h0, -1);
        check("rd9_next", rd_m, COR ? 1 : 8);

        // Reset while a read is in flight
        avmm_address = 8'd9;
        avmm_read    = 1'b1;
        tick();
        avmm_read = 1'b0;
        rst       = 1'b1;
        tick();
        check("rstmid_rdv", {61'b0, rdv_m, rdv_w, rdv_s}, 0);
        check("rstmid_rdata", {rdata_m, rdata_w}, 0);
        check("rstmid_snap", {63'b0, |{snap_m, snap_w, snap_s}}, 0);
        rst = 1'b0;
        tick();
        check("rstmid_rdv_after", rdv_m, 0);
        check("rstmid_rdata_after", rdata_m, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
